ps2_key_sequencer: RTL

System-clock PS/2 keyboard front end and key-event scheduler for the game core. Samples the raw keyboard clock/data pins, sequences reception of each 11-bit PS/2 frame with a bit counter and watchdog, and validates start/parity/stop. Interprets the make/break/extended-code byte stream and hands each direction or select key press to the game FSM through a valid/ack handshake. Sits between the PS/2 pins (M16 clock, M15 data) and the game logic.

---
 rtl/ps2_key_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard receiver and key-event scheduler: synchronises the pins, frames
// 11-bit PS/2 words, decodes make/break/extended codes and offers key events on a valid/ack handshake.
module ps2_key_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2CLK,
  input  logic       iPS2D,
  input  logic       iAck,
  output logic       oKeyValid,
  output logic [3:0] oDireccion,
  output logic       oSelect,
  output logic       oFrameErr
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_e;

  state_e         state_q, state_d;
  logic           clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [3:0]     bitcnt_q;
  logic [9:0]     shift_q;
  logic [WDW-1:0] wd_q;
  logic           brk_q, ext_q;
  logic           ev_q, ev_sel_q;
  logic [3:0]     ev_dir_q;
  logic           kv_q, sel_q, ferr_q;
  logic [3:0]     dir_q;

  logic       fall, wd_expire, frame_ok, byte_stb, frame_bad, ferr_d;
  logic [3:0] dec_dir;
  logic       dec_sel;

  // Synchronisers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= iPS2CLK;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= iPS2D;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall      = clk_prev_q & ~clk_s2_q;
  assign wd_expire = (state_q == S_SHIFT) && !fall && (wd_q == WD_LAST);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall && !dat_s2_q) state_d = S_SHIFT;
      S_SHIFT: begin
        if (fall && bitcnt_q == 4'd10) state_d = S_CHECK;
        else if (wd_expire)            state_d = S_IDLE;
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // shift_q holds {stop, parity, data[7:0]} once the stop bit is in.
  always_comb begin
    frame_ok  = (^shift_q[8:0]) & shift_q[9];
    byte_stb  = (state_q == S_CHECK) && frame_ok;
    frame_bad = (state_q == S_CHECK) && !frame_ok;
    ferr_d    = frame_bad || wd_expire;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bitcnt_q <= '0;
      shift_q  <= '0;
      wd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (fall && !dat_s2_q) begin
          bitcnt_q <= 4'd1;
          shift_q  <= '0;
          wd_q     <= '0;
        end
        S_SHIFT: begin
          if (fall) begin
            shift_q  <= {dat_s2_q, shift_q[9:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            wd_q     <= '0;
          end else if (wd_expire) begin
            bitcnt_q <= '0;
            wd_q     <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          bitcnt_q <= '0;
          wd_q     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    dec_dir = 4'b0000;
    dec_sel = 1'b0;
    if (!ext_q) begin
      case (shift_q[7:0])
        8'h1C:   dec_dir = 4'b0001;
        8'h1B:   dec_dir = 4'b0010;
        8'h23:   dec_dir = 4'b0100;
        8'h1D:   dec_dir = 4'b1000;
        8'h29:   dec_sel = 1'b1;
        default: ;
      endcase
    end else begin
      case (shift_q[7:0])
        8'h6B:   dec_dir = 4'b0001;
        8'h72:   dec_dir = 4'b0010;
        8'h74:   dec_dir = 4'b0100;
        8'h75:   dec_dir = 4'b1000;
        default: ;
      endcase
    end
  end

  // Registered event keeps the handshake one cycle behind the CHECK state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      ev_q     <= 1'b0;
      ev_dir_q <= '0;
      ev_sel_q <= 1'b0;
    end else begin
      ev_q <= 1'b0;
      if (frame_bad) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (byte_stb) begin
        if (shift_q[7:0] == 8'hF0) brk_q <= 1'b1;
        else if (shift_q[7:0] == 8'hE0) ext_q <= 1'b1;
        else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (!brk_q && (dec_dir != 4'b0000 || dec_sel)) begin
            ev_q     <= 1'b1;
            ev_dir_q <= dec_dir;
            ev_sel_q <= dec_sel;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      kv_q   <= 1'b0;
      dir_q  <= '0;
      sel_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      if (ev_q && (!kv_q || iAck)) begin
        kv_q  <= 1'b1;
        dir_q <= ev_dir_q;
        sel_q <= ev_sel_q;
      end else if (kv_q && iAck) begin
        kv_q  <= 1'b0;
        dir_q <= '0;
        sel_q <= 1'b0;
      end
    end
  end

  assign oKeyValid  = kv_q;
  assign oDireccion = dir_q;
  assign oSelect    = sel_q;
  assign oFrameErr  = ferr_q;

endmodule
